// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flip-flop, LSB first,
// with a start/ready/done handshake and registered sum, carry-out and signed overflow.
//
// state | meaning
// IDLE  | ready=1, waiting for start; accepted start loads operands and carry-in
// RUN   | busy=1, one bit per clock through the full-adder cell
// DONE  | done=1 for one cycle, results valid; returns to IDLE unconditionally
module serial_adder_nbit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH) + 1;
    // Terminal count is WIDTH-1, so the counter never has to represent WIDTH itself.
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             c;
    logic             s_bit;
    logic             c_nxt;
    logic             last_bit;
    logic             accept;

    assign s_bit    = a_sh[0] ^ b_sh[0] ^ c;
    assign c_nxt    = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
    assign res_nxt  = {s_bit, res_sh[WIDTH-1:1]};
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh     <= '0;
            b_sh     <= '0;
            res_sh   <= '0;
            cnt      <= '0;
            c        <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            c    <= cin;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            c      <= c_nxt;
            res_sh <= res_nxt;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                // c still holds the carry into the MSB on this edge
                sum      <= res_nxt;
                cout     <= c_nxt;
                overflow <= c ^ c_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Self-checking bench for serial_adder_nbit at WIDTH 8, 4 and 16: vector table,
// handshake/reset sequences, exhaustive 4-bit sweep and random 16-bit ops.
module tb_serial_adder_nbit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc++;

    logic       rst8, start8, cin8, ready8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, sum8;
    logic        rst4, start4, cin4, ready4, busy4, done4, cout4, ovf4;
    logic [3:0]  a4, b4, sum4;
    logic        rst16, start16, cin16, ready16, busy16, done16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;

    serial_adder_nbit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );
    serial_adder_nbit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .overflow(ovf4)
    );
    serial_adder_nbit #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst16), .start(start16), .a(a16), .b(b16), .cin(cin16),
        .ready(ready16), .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
    );

    // Expected results packed as {overflow, cout, sum zero-extended to 32 bits}
    logic [33:0] q8[$];
    logic [33:0] q4[$];
    logic [33:0] q16[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic ci);
        logic [32:0] t;
        logic [31:0] m;
        logic        ov;
        t  = {1'b0, a} + {1'b0, b} + 33'(ci);
        m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        ov = (a[w-1] == b[w-1]) && (t[w-1] != a[w-1]);
        return {ov, t[w], t[31:0] & m};
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] ex);
        n_vec++;
        if (act !== ex) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, ex, $time);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    always @(negedge clk) begin
        if (!rst8 && done8) begin
            if (q8.size() == 0) flag("dut8 unexpected done");
            else check("dut8 result", {ovf8, cout8, 24'd0, sum8}, q8.pop_front());
        end
        if (!rst4 && done4) begin
            if (q4.size() == 0) flag("dut4 unexpected done");
            else check("dut4 result", {ovf4, cout4, 28'd0, sum4}, q4.pop_front());
        end
        if (!rst16 && done16) begin
            if (q16.size() == 0) flag("dut16 unexpected done");
            else check("dut16 result", {ovf16, cout16, 16'd0, sum16}, q16.pop_front());
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                          input logic [33:0] ex, input bit lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready8) begin
            flag("dut8 ready timeout");
            return;
        end
        a8 = a; b8 = b; cin8 = ci; start8 = 1'b1;
        q8.push_back(ex);
        @(posedge clk);
        #1 start8 = 1'b0;
        if (lat) begin
            n = 0;
            do begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end while (!done8 && n < 40);
            check("dut8 latency", 34'(n), 34'd8);
        end
    endtask

    task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic ci);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready4) begin
            flag("dut4 ready timeout");
            return;
        end
        a4 = a; b4 = b; cin4 = ci; start4 = 1'b1;
        q4.push_back(model(4, 32'(a), 32'(b), ci));
        @(posedge clk);
        #1 start4 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic ci);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready16) begin
            flag("dut16 ready timeout");
            return;
        end
        a16 = a; b16 = b; cin16 = ci; start16 = 1'b1;
        q16.push_back(model(16, 32'(a), 32'(b), ci));
        @(posedge clk);
        #1 start16 = 1'b0;
    endtask

    task automatic seq8();
        vec_t tbl[8];
        int   n, dones, t1, t2;
        logic [33:0] ex;
        tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[6] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[7] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            issue8(tbl[i].a, tbl[i].b, tbl[i].cin,
                   {tbl[i].ovf, tbl[i].cout, 24'd0, tbl[i].sum}, 1'b1);
        end

        // Second start during RUN is ignored; old outputs hold while running.
        issue8(8'h0F, 8'h01, 1'b0, {2'b00, 24'd0, 8'h10}, 1'b0);
        @(negedge clk);
        check("hold during run", {ovf8, cout8, 24'd0, sum8}, {2'b10, 24'd0, 8'h80});
        check("ready low in run", {32'd0, ready8, busy8}, {32'd0, 2'b01});
        a8 = 8'h55; b8 = 8'h55; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            if (ready8) flag("ready high before done");
            @(negedge clk);
            n++;
        end
        check("ready low in done", {33'd0, ready8}, 34'd0);
        @(negedge clk);
        check("ready after done", {32'd0, ready8, busy8}, {32'd0, 2'b10});
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check("no queued op", 34'(dones), 34'd0);

        // Reset mid-RUN with start also high: reset wins, partial result discarded.
        issue8(8'h0F, 8'h01, 1'b0, {2'b00, 24'd0, 8'h10}, 1'b0);
        repeat (3) @(negedge clk);
        rst8 = 1'b1; start8 = 1'b1; a8 = 8'hAA;
        @(negedge clk);
        check("rst wins over start", {32'd0, ready8, busy8}, {32'd0, 2'b10});
        @(negedge clk);
        rst8 = 1'b0; start8 = 1'b0;
        q8.delete();
        @(negedge clk);
        check("state after mid-run reset", {21'd0, ready8, busy8, done8, ovf8, cout8, sum8},
              {21'd0, 1'b1, 4'b0000, 8'h00});
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) dones++;
        end
        check("no done after reset", 34'(dones), 34'd0);

        // start held high: back-to-back ops every WIDTH+2 cycles.
        ex = model(8, 32'h12, 32'h34, 1'b1);
        q8.push_back(ex);
        q8.push_back(ex);
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!done8 && n < 30);
        t1 = cyc;
        n = 0;
        do begin @(negedge clk); n++; end while (!done8 && n < 30);
        t2 = cyc;
        start8 = 1'b0;
        check("continuous start period", 34'(t2 - t1), 34'd10);
    endtask

    task automatic seq4();
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int ci = 0; ci < 2; ci++)
                    issue4(4'(a), 4'(b), 1'(ci));
    endtask

    task automatic seq16();
        issue16(16'hFFFF, 16'h0000, 1'b1);
        issue16(16'h7FFF, 16'h0001, 1'b0);
        issue16(16'h8000, 16'h8000, 1'b0);
        for (int i = 0; i < 1000; i++)
            issue16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int n;
        rst8 = 1'b1; rst4 = 1'b1; rst16 = 1'b1;
        start8 = 1'b0; start4 = 1'b0; start16 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a4 = '0; b4 = '0; cin4 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b0; rst4 = 1'b0; rst16 = 1'b0;
        check("reset state", {21'd0, ready8, busy8, done8, ovf8, cout8, sum8},
              {21'd0, 1'b1, 4'b0000, 8'h00});
        fork
            seq8();
            seq4();
            seq16();
        join
        n = 0;
        while ((q8.size() + q4.size() + q16.size()) != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if ((q8.size() + q4.size() + q16.size()) != 0) flag("results outstanding at end");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
